// File: rtl/alu_pkg.sv
// Shared opcode, FSM state and flag-index definitions for the pipelined ALU.
// Pure declarations, no logic.
// Imported by alu_pipe and its sub-modules.
package alu_pkg;

    // Opcodes carried on alu_op
    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_OR  = 4'h1;
    localparam logic [3:0] OP_XOR = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_NOT = 4'h5;
    localparam logic [3:0] OP_SLL = 4'h6;
    localparam logic [3:0] OP_SRL = 4'h7;
    localparam logic [3:0] OP_SRA = 4'h8;
    localparam logic [3:0] OP_MUL = 4'h9;
    localparam logic [3:0] OP_CMP = 4'hA;

    // Control FSM: IDLE accepts work, MUL waits on the iterative multiplier
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    // Bit positions inside cond_fc = {F,C}
    localparam int FC_F = 1;
    localparam int FC_C = 0;

    // Bit positions inside cond_znl = {N,Z,L}
    localparam int ZNL_N = 2;
    localparam int ZNL_Z = 1;
    localparam int ZNL_L = 0;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier, one multiplier bit per cycle.
// start at edge N -> o_done high after edge N+WIDTH; held until i_ack.
// Result is frozen while done and not acknowledged; a new start overrides.
module alu_mul_iter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_ack,
    output logic             o_done,
    output logic [WIDTH-1:0] o_prod_lo,
    output logic             o_prod_hi_nz
);
    import alu_pkg::*;

    localparam int              CNT_W   = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(WIDTH);

    logic                 r_run;
    logic [CNT_W-1:0]     r_cnt;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;

    // Done once every multiplier bit has been consumed
    assign o_done       = r_run && (r_cnt == LP_LAST);
    assign o_prod_lo    = r_acc[WIDTH-1:0];
    assign o_prod_hi_nz = |r_acc[2*WIDTH-1:WIDTH];

    // Load operands on start, then add the shifted multiplicand for each set bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_run    <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (i_start) begin
            r_run    <= 1'b1;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, i_a};
            r_mplier <= i_b;
        end else if (o_done) begin
            if (i_ack) begin
                r_run <= 1'b0;
            end
        end else if (r_run) begin
            if (r_mplier[0]) begin
                r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU: operand register at accept, result/flag register one edge later.
// Latency 2 edges for single-cycle ops (1/cycle throughput), WIDTH+1 edges for MUL.
// in_ready drops while the result is held unretired or a multiply is running.
module alu_pipe #(
    parameter int WIDTH      = 16,
    parameter int SHAMT_W    = $clog2(WIDTH),
    parameter int ENABLE_MUL = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_op,
    input  logic             set_znl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [1:0]       cond_fc,
    output logic [2:0]       cond_znl,
    output logic             busy
);
    import alu_pkg::*;

    localparam bit LP_MUL_EN = (ENABLE_MUL != 0);

    state_t             r_state;
    logic               r_busy;

    logic               r_s1_vld;
    logic [3:0]         r_s1_op;
    logic [WIDTH-1:0]   r_s1_a;
    logic [WIDTH-1:0]   r_s1_b;
    logic               r_s1_znl;

    logic [WIDTH-1:0]   r_result;
    logic               r_out_valid;
    logic [1:0]         r_fc;
    logic [2:0]         r_znl;

    logic               w_adv;
    logic               w_accept;
    logic               w_is_mul;
    logic               w_mul_start;
    logic               w_mul_done;
    logic               w_mul_wr;
    logic               w_mul_hi_nz;
    logic [WIDTH-1:0]   w_mul_lo;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_diff;
    logic [WIDTH-1:0]   w_neg_b;
    logic signed [WIDTH-1:0] w_sra;
    logic               w_lt_u;
    logic               w_lt_s;
    logic               w_add_ovf;
    logic               w_sub_ovf;
    logic [WIDTH-1:0]   w_res;
    logic [1:0]         w_fc;
    logic [2:0]         w_znl;

    // Output slot is free when empty or retiring this cycle
    assign w_adv       = !r_out_valid || out_ready;
    assign in_ready    = (r_state == ST_IDLE) && w_adv;
    assign w_accept    = in_valid && in_ready;
    assign w_is_mul    = LP_MUL_EN && (alu_op == OP_MUL);
    assign w_mul_start = w_accept && w_is_mul;
    assign w_mul_wr    = (r_state == ST_MUL) && w_mul_done && w_adv;

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign cond_fc   = r_fc;
    assign cond_znl  = r_znl;
    assign busy      = r_busy;

    // Operand stage: multiplies bypass it and go straight to the multiplier
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_vld <= 1'b0;
            r_s1_op  <= '0;
            r_s1_a   <= '0;
            r_s1_b   <= '0;
            r_s1_znl <= 1'b0;
        end else if (w_accept) begin
            r_s1_vld <= !w_is_mul;
            r_s1_op  <= alu_op;
            r_s1_a   <= a;
            r_s1_b   <= b;
            r_s1_znl <= set_znl;
        end else if (w_adv) begin
            r_s1_vld <= 1'b0;
        end
    end

    assign w_sum     = {1'b0, r_s1_a} + {1'b0, r_s1_b};
    assign w_diff    = r_s1_a - r_s1_b;
    assign w_neg_b   = -r_s1_b;
    assign w_sra     = $signed(r_s1_a) >>> r_s1_b[SHAMT_W-1:0];
    assign w_lt_u    = r_s1_a < r_s1_b;
    assign w_lt_s    = $signed(r_s1_a) < $signed(r_s1_b);
    assign w_add_ovf = (r_s1_a[WIDTH-1] == r_s1_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_s1_a[WIDTH-1]);
    assign w_sub_ovf = (r_s1_a[WIDTH-1] != r_s1_b[WIDTH-1]) && (w_diff[WIDTH-1] != r_s1_a[WIDTH-1]);

    // Single-cycle op decode; flags default to their held values
    always_comb begin
        w_res = '0;
        w_fc  = r_fc;
        w_znl = r_znl;
        case (r_s1_op)
            OP_AND: w_res = r_s1_a & r_s1_b;
            OP_OR:  w_res = r_s1_a | r_s1_b;
            OP_XOR: w_res = r_s1_a ^ r_s1_b;
            OP_NOT: w_res = ~r_s1_a;
            OP_ADD: begin
                w_res       = w_sum[WIDTH-1:0];
                w_fc[FC_C]  = w_sum[WIDTH];
                w_fc[FC_F]  = w_add_ovf;
            end
            OP_SUB: begin
                w_res       = w_diff;
                w_fc[FC_C]  = w_lt_u;
                w_fc[FC_F]  = w_sub_ovf;
            end
            OP_CMP: begin
                w_fc[FC_C]  = w_lt_u;
                w_fc[FC_F]  = w_sub_ovf;
            end
            // Negative b shifts right by |b|; shift counts >= WIDTH naturally yield 0
            OP_SLL: w_res = r_s1_b[WIDTH-1] ? (r_s1_a >> w_neg_b) : (r_s1_a << r_s1_b);
            OP_SRL: w_res = r_s1_a >> 1;
            // Any upper shift bit set means the shift exceeds the width: pure sign fill
            OP_SRA: w_res = (|r_s1_b[WIDTH-1:SHAMT_W]) ? {WIDTH{r_s1_a[WIDTH-1]}} : w_sra;
            default: w_res = '0;
        endcase
        if (r_s1_znl && ((r_s1_op == OP_SUB) || (r_s1_op == OP_CMP))) begin
            w_znl[ZNL_N] = w_lt_s;
            w_znl[ZNL_Z] = (r_s1_a == r_s1_b);
            w_znl[ZNL_L] = w_lt_u;
        end
    end

    // Result and flag register; multiply completion and stage-1 advance never coincide
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_result    <= '0;
            r_out_valid <= 1'b0;
            r_fc        <= '0;
            r_znl       <= '0;
        end else if (w_mul_wr) begin
            r_result    <= w_mul_lo;
            r_out_valid <= 1'b1;
            r_fc[FC_F]  <= 1'b0;
            r_fc[FC_C]  <= w_mul_hi_nz;
        end else if (r_s1_vld && w_adv) begin
            r_result    <= w_res;
            r_out_valid <= 1'b1;
            r_fc        <= w_fc;
            r_znl       <= w_znl;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Control FSM with registered busy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_mul_start) begin
                        r_state <= ST_MUL;
                        r_busy  <= 1'b1;
                    end
                end
                ST_MUL: begin
                    if (w_mul_wr) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    generate
        if (LP_MUL_EN) begin : g_mul
            alu_mul_iter #(
                .WIDTH (WIDTH)
            ) u_mul (
                .clk          (clk),
                .reset        (reset),
                .i_start      (w_mul_start),
                .i_a          (a),
                .i_b          (b),
                .i_ack        (w_mul_wr),
                .o_done       (w_mul_done),
                .o_prod_lo    (w_mul_lo),
                .o_prod_hi_nz (w_mul_hi_nz)
            );
        end else begin : g_no_mul
            assign w_mul_done  = 1'b0;
            assign w_mul_lo    = '0;
            assign w_mul_hi_nz = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: vector table plus multiply, reset and backpressure sequences.
module tb_alu_pipe;
    import alu_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         set_znl = 1'b0;
    logic         out_ready = 1'b1;
    logic [3:0]   alu_op = 4'h0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready;
    logic         out_valid;
    logic         busy;
    logic [W-1:0] result;
    logic [1:0]   cond_fc;
    logic [2:0]   cond_znl;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_pipe #(
        .WIDTH      (W),
        .SHAMT_W    (4),
        .ENABLE_MUL (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .set_znl   (set_znl),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cond_fc   (cond_fc),
        .cond_znl  (cond_znl),
        .busy      (busy)
    );

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         zn;
        logic [W-1:0] res;
        logic [1:0]   fc;
        logic [2:0]   znl;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic [3:0] op, input logic [W-1:0] va, input logic [W-1:0] vb,
                                input logic zn, input logic [W-1:0] res, input logic [1:0] fc,
                                input logic [2:0] znl);
        vec_t v;
        v.op = op; v.va = va; v.vb = vb; v.zn = zn; v.res = res; v.fc = fc; v.znl = znl;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [3:0] op, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic zn);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("send_in_ready", {31'd0, in_ready}, 32'd1);
        alu_op = op; a = va; b = vb; set_znl = zn; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; a = 16'hDEAD; b = 16'hBEEF; set_znl = ~zn; alu_op = OP_AND;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Backpressure sequence state
    logic [W-1:0] xa [6];
    logic [W-1:0] xb [6];
    logic [W-1:0] xexp [6];
    int           sent;
    int           got;
    logic         hold;
    logic [W-1:0] held;
    int           lat;
    int           rise;
    int           rdy_bad;
    int           busy_bad;
    int           ov_seen;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        // Flags carry over between rows, so each expectation includes prior state
        vq.push_back(mk(OP_ADD, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 2'b10, 3'b000));
        vq.push_back(mk(OP_SUB, 16'h0003, 16'h0005, 1'b1, 16'hFFFE, 2'b01, 3'b101));
        vq.push_back(mk(OP_AND, 16'h00F0, 16'h0FF0, 1'b1, 16'h00F0, 2'b01, 3'b101));
        vq.push_back(mk(OP_SLL, 16'h00F0, 16'hFFFC, 1'b0, 16'h000F, 2'b01, 3'b101));
        vq.push_back(mk(OP_SLL, 16'h00F0, 16'h0010, 1'b0, 16'h0000, 2'b01, 3'b101));
        vq.push_back(mk(OP_SLL, 16'h0001, 16'h0004, 1'b0, 16'h0010, 2'b01, 3'b101));
        vq.push_back(mk(OP_SRA, 16'h8000, 16'h0003, 1'b0, 16'hF000, 2'b01, 3'b101));
        vq.push_back(mk(OP_SRA, 16'h8000, 16'h0013, 1'b0, 16'hFFFF, 2'b01, 3'b101));
        vq.push_back(mk(OP_SRA, 16'h4000, 16'h0100, 1'b0, 16'h0000, 2'b01, 3'b101));
        vq.push_back(mk(OP_SRL, 16'h8001, 16'h0007, 1'b0, 16'h4000, 2'b01, 3'b101));
        vq.push_back(mk(OP_OR,  16'h1234, 16'h0F0F, 1'b0, 16'h1F3F, 2'b01, 3'b101));
        vq.push_back(mk(OP_XOR, 16'h1234, 16'h0F0F, 1'b0, 16'h1D3B, 2'b01, 3'b101));
        vq.push_back(mk(OP_NOT, 16'h00FF, 16'h0000, 1'b0, 16'hFF00, 2'b01, 3'b101));
        vq.push_back(mk(OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 2'b01, 3'b101));
        vq.push_back(mk(OP_ADD, 16'h8000, 16'h8000, 1'b0, 16'h0000, 2'b11, 3'b101));
        vq.push_back(mk(OP_CMP, 16'h0005, 16'h0005, 1'b1, 16'h0000, 2'b00, 3'b010));
        vq.push_back(mk(OP_SUB, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 2'b10, 3'b100));
        vq.push_back(mk(OP_CMP, 16'h0001, 16'hFFFF, 1'b0, 16'h0000, 2'b01, 3'b100));
        vq.push_back(mk(4'hB,   16'h1234, 16'h0001, 1'b1, 16'h0000, 2'b01, 3'b100));
        vq.push_back(mk(OP_ADD, 16'h0002, 16'h0003, 1'b1, 16'h0005, 2'b00, 3'b100));
        vq.push_back(mk(OP_MUL, 16'h0003, 16'h0005, 1'b1, 16'h000F, 2'b00, 3'b100));
        vq.push_back(mk(OP_MUL, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0001, 2'b01, 3'b100));

        xa   = '{16'h0001, 16'h00F0, 16'hAAAA, 16'h1234, 16'hFFFF, 16'h8000};
        xb   = '{16'h0001, 16'h0F00, 16'h5555, 16'h4321, 16'h00FF, 16'h8001};
        xexp = '{16'h0000, 16'h0FF0, 16'hFFFF, 16'h5115, 16'hFF00, 16'h0001};

        // Reset state
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_result",    {16'd0, result},    32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_fc",        {30'd0, cond_fc},   32'd0);
        chk("rst_znl",       {29'd0, cond_znl},  32'd0);
        chk("rst_busy",      {31'd0, busy},      32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);

        // Vector table, consumer always ready
        out_ready = 1'b1;
        foreach (vq[i]) begin
            send(vq[i].op, vq[i].va, vq[i].vb, vq[i].zn);
            wait_out(lat);
            chk($sformatf("v%0d_valid", i),  {31'd0, out_valid}, 32'd1);
            chk($sformatf("v%0d_lat", i),    lat - 1, (vq[i].op == OP_MUL) ? W + 1 : 1);
            chk($sformatf("v%0d_result", i), {16'd0, result},    {16'd0, vq[i].res});
            chk($sformatf("v%0d_fc", i),     {30'd0, cond_fc},   {30'd0, vq[i].fc});
            chk($sformatf("v%0d_znl", i),    {29'd0, cond_znl},  {29'd0, vq[i].znl});
        end

        // Multiply latency and stall: 0x0100*0x0100 overflows into the upper half
        send(OP_MUL, 16'h0100, 16'h0100, 1'b0);
        chk("mul_busy_start",     {31'd0, busy},     32'd1);
        chk("mul_in_ready_start", {31'd0, in_ready}, 32'd0);
        rise = 0; rdy_bad = 0; busy_bad = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                rise = c;
                break;
            end
            if (in_ready) rdy_bad++;
            if (!busy) busy_bad++;
        end
        chk("mul_latency",   rise,              W + 1);
        chk("mul_stall",     rdy_bad,           0);
        chk("mul_busy_hold", busy_bad,          0);
        chk("mul_busy_done", {31'd0, busy},     32'd0);
        chk("mul_result",    {16'd0, result},   32'd0);
        chk("mul_fc",        {30'd0, cond_fc},  32'd1);

        // Reset in the middle of a multiply
        send(OP_MUL, 16'h1234, 16'h0002, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("mrst_busy",      {31'd0, busy},      32'd0);
        chk("mrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mrst_result",    {16'd0, result},    32'd0);
        chk("mrst_fc",        {30'd0, cond_fc},   32'd0);
        chk("mrst_znl",       {29'd0, cond_znl},  32'd0);
        @(negedge clk);
        reset = 1'b0;
        ov_seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) ov_seen++;
        end
        chk("mrst_no_result", ov_seen, 0);

        // Back-to-back XOR with out_ready pattern 1,0,1
        sent = 0; got = 0; hold = 1'b0; held = '0;
        for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
            @(negedge clk);
            if (hold) begin
                chk("xor_hold_valid",  {31'd0, out_valid}, 32'd1);
                chk("xor_hold_stable", {16'd0, result},    {16'd0, held});
            end
            out_ready = ((cyc % 3) != 1);
            if (sent < 6) begin
                in_valid = 1'b1; alu_op = OP_XOR; a = xa[sent]; b = xb[sent]; set_znl = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            chk("xor_in_ready", {31'd0, in_ready}, {31'd0, (!busy && (!out_valid || out_ready))});
            if (out_valid && out_ready) begin
                chk($sformatf("xor_out%0d", got), {16'd0, result}, {16'd0, xexp[got]});
                got++;
            end
            hold = out_valid && !out_ready;
            held = result;
            if (in_valid && in_ready) sent++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("xor_count", got, 6);
        repeat (3) @(negedge clk);
        chk("xor_no_extra", {31'd0, out_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
